// File: rtl/lfsr_pkg.sv
// Shared definitions for the 16-bit PRBS generator/checker pair.
// The polynomial is defined only here, so the generator and the checker
// cannot drift apart.
package lfsr_pkg;

  localparam int LFSR_W = 16;
  localparam int CNT_W  = 8;

  // Feedback taps for x^16+x^14+x^13+x^11+1 (word bits 15,13,12,10)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } lfsr_chk_state_e;

  // Fibonacci step: shift left, feedback bit is the parity of the tapped bits
  function automatic logic [LFSR_W-1:0] lfsr16_next(input logic [LFSR_W-1:0] w);
    return {w[LFSR_W-2:0], ^(w & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/prbs_checker_16.sv
// Receive-side checker for the 16-bit PRBS generator. Predicts each word
// from the previous one, acquires lock after LOCK_CNT consecutive matches,
// then freewheels its prediction and counts mismatches until UNLOCK_CNT
// consecutive misses drop it back to tracking.
module prbs_checker_16
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4,
  parameter int ERR_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [LFSR_W-1:0] lfsr_in,
  input  logic              clear_cnt,
  output logic              locked,
  output logic              error,
  output logic [ERR_W-1:0]  err_count
);

  localparam logic [CNT_W-1:0] LOCK_C   = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] UNLOCK_C = CNT_W'(UNLOCK_CNT);

  lfsr_chk_state_e   state_q;
  logic [LFSR_W-1:0] prev_q;
  logic [CNT_W-1:0]  good_q;
  logic [CNT_W-1:0]  bad_q;
  logic              locked_q;
  logic              error_q;
  logic [ERR_W-1:0]  err_cnt_q;

  logic [LFSR_W-1:0] expected;
  logic              match;
  logic              err_hit;

  // Prediction of the current word from the last accepted one
  always_comb begin
    expected = lfsr16_next(prev_q);
    match    = (lfsr_in == expected);
    err_hit  = enable && (state_q == LOCKED) && !match;
  end

  // Lock FSM with its prediction register, run counters and registered flags.
  // NOTE: every register here uses <= so all of them see the pre-edge values of
  // each other; mixing in = would make the result depend on statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= SEARCH;
      prev_q   <= '0;
      good_q   <= '0;
      bad_q    <= '0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      // error is a one-cycle pulse; only a LOCKED mismatch raises it
      error_q <= 1'b0;
      if (enable) begin
        case (state_q)
          SEARCH: begin
            // All-zero is the LFSR lockup word, never a valid seed
            if (lfsr_in != '0) begin
              state_q <= TRACK;
              prev_q  <= lfsr_in;
              good_q  <= '0;
            end
          end
          TRACK: begin
            // Re-seed from the received word so a matching run can start anywhere
            prev_q <= lfsr_in;
            if (lfsr_in == '0) begin
              state_q <= SEARCH;
              good_q  <= '0;
            end else if (match) begin
              good_q <= good_q + CNT_W'(1);
              if (good_q + CNT_W'(1) == LOCK_C) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                bad_q    <= '0;
              end
            end else begin
              good_q <= '0;
            end
          end
          LOCKED: begin
            // Flywheel: keep predicting from our own sequence, not the input
            if (match) begin
              bad_q  <= '0;
              prev_q <= expected;
            end else begin
              error_q <= 1'b1;
              bad_q   <= bad_q + CNT_W'(1);
              if (bad_q + CNT_W'(1) == UNLOCK_C) begin
                state_q  <= TRACK;
                locked_q <= 1'b0;
                prev_q   <= lfsr_in;
                good_q   <= '0;
              end else begin
                prev_q <= expected;
              end
            end
          end
          default: begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating mismatch counter; clear takes priority over an increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
    end else if (clear_cnt) begin
      err_cnt_q <= '0;
    end else if (err_hit && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_W'(1);
    end
  end

  assign locked    = locked_q;
  assign error     = error_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_prbs_checker_16.sv
// Self-checking bench for prbs_checker_16. Two instances share the stimulus:
// one with the default 16-bit error counter and one with a 4-bit counter so
// saturation is reachable. A behavioural model tracks lock status and counts.
module tb_prbs_checker_16;

  localparam int LOCK_N   = 8;
  localparam int UNLOCK_N = 4;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [15:0] lfsr_in;
  logic        clear_cnt;

  logic        locked,   error;
  logic [15:0] err_count;
  logic        locked_s, error_s;
  logic [3:0]  err_count_s;

  prbs_checker_16 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .lfsr_in   (lfsr_in),
    .clear_cnt (clear_cnt),
    .locked    (locked),
    .error     (error),
    .err_count (err_count)
  );

  prbs_checker_16 #(.ERR_W(4)) dut_s (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .lfsr_in   (lfsr_in),
    .clear_cnt (clear_cnt),
    .locked    (locked_s),
    .error     (error_s),
    .err_count (err_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  // mode: 0 = hunting for a seed, 1 = counting a matching run, 2 = locked
  int          m_mode;
  logic [15:0] m_prev;
  int          m_run;
  int          m_miss;
  logic        m_error;
  int          m_cnt;
  int          m_cnt_s;

  // generator model
  logic [15:0] gen;
  logic [15:0] last_din;

  function automatic logic [15:0] nx(input logic [15:0] w);
    logic fb;
    fb = w[15] ^ w[13] ^ w[12] ^ w[10];
    return {w[14:0], fb};
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_prev  = 16'h0000;
    m_run   = 0;
    m_miss  = 0;
    m_error = 1'b0;
    m_cnt   = 0;
    m_cnt_s = 0;
  endtask

  task automatic model_step(input logic en, input logic [15:0] din, input logic clr);
    logic [15:0] pred;
    m_error = 1'b0;
    if (en) begin
      pred = nx(m_prev);
      if (m_mode == 0) begin
        if (din != 0) begin
          m_mode = 1;
          m_prev = din;
          m_run  = 0;
        end
      end else if (m_mode == 1) begin
        if (din == 0) begin
          m_mode = 0;
          m_run  = 0;
        end else if (din == pred) begin
          m_run++;
          if (m_run == LOCK_N) begin
            m_mode = 2;
            m_miss = 0;
          end
        end else begin
          m_run = 0;
        end
        m_prev = din;
      end else begin
        if (din == pred) begin
          m_miss = 0;
          m_prev = pred;
        end else begin
          m_error = 1'b1;
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt_s < 15) m_cnt_s++;
          m_miss++;
          if (m_miss == UNLOCK_N) begin
            m_mode = 1;
            m_prev = din;
            m_run  = 0;
          end else begin
            m_prev = pred;
          end
        end
      end
    end
    if (clr) begin
      m_cnt   = 0;
      m_cnt_s = 0;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".locked"},  32'(locked),      32'(m_mode == 2));
    chk({tag, ".error"},   32'(error),       32'(m_error));
    chk({tag, ".count"},   32'(err_count),   32'(m_cnt));
    chk({tag, ".locked_s"},32'(locked_s),    32'(m_mode == 2));
    chk({tag, ".error_s"}, 32'(error_s),     32'(m_error));
    chk({tag, ".count_s"}, 32'(err_count_s), 32'(m_cnt_s));
  endtask

  // One clock: drive at negedge, let the DUT sample, compare 1 time unit later
  task automatic cycle(input string tag, input logic en, input logic corrupt,
                       input logic [15:0] cval, input logic clr);
    logic [15:0] din;
    @(negedge clk);
    if (en) begin
      din      = corrupt ? cval : gen;
      gen      = nx(gen);
      last_din = din;
    end else begin
      din = last_din;
    end
    enable    = en;
    lfsr_in   = din;
    clear_cnt = clr;
    @(posedge clk);
    model_step(en, din, clr);
    #1;
    check_all(tag);
  endtask

  task automatic clean(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b1, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic bad(input string tag, input int n, input logic [15:0] v);
    for (int i = 0; i < n; i++) cycle(tag, 1'b1, 1'b1, v, 1'b0);
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    lfsr_in   = 16'h0;
    clear_cnt = 1'b0;
    gen       = 16'hACE1;
    last_din  = 16'h0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Clean lock: 8 words leave it unlocked, the 9th locks
    clean("lock_pre", LOCK_N);
    chk("lock_not_yet", 32'(locked), 32'(0));
    clean("lock_edge", 1);
    chk("lock_9th", 32'(locked), 32'(1));
    clean("lock_hold", 4);

    // Enable gaps with the input frozen
    for (int i = 0; i < 3; i++) cycle("gap", 1'b0, 1'b0, 16'h0, 1'b0);
    clean("gap_resume", 3);
    chk("gap_locked", 32'(locked), 32'(1));

    // Single corruption to zero: one pulse, flywheel keeps lock
    bad("corrupt", 1, 16'h0000);
    chk("corrupt_pulse", 32'(error), 32'(1));
    clean("corrupt_after", 3);
    chk("corrupt_cnt", 32'(err_count), 32'(1));

    // Loss of lock after UNLOCK_N consecutive bad words, then relock
    bad("unlock", UNLOCK_N, 16'h1234);
    chk("unlock_cnt", 32'(err_count), 32'(5));
    chk("unlock_fall", 32'(locked), 32'(0));
    clean("relock", LOCK_N + 2);
    chk("relock", 32'(locked), 32'(1));

    // Randomised traffic: enable gaps, random corruptions and clears
    for (int i = 0; i < 400; i++) begin
      logic en, cor, clr;
      en  = ($urandom_range(0, 3) != 0);
      cor = ($urandom_range(0, 11) == 0);
      clr = ($urandom_range(0, 40) == 0);
      cycle("rand", en, cor, 16'($urandom()), clr);
    end
    clean("rand_settle", 20);

    // Saturation of the 4-bit counter across repeated unlock/relock
    for (int r = 0; r < 5; r++) begin
      clean("sat_relock", LOCK_N + 2);
      bad("sat_bad", UNLOCK_N, 16'h1234);
    end
    chk("sat_cnt_s", 32'(err_count_s), 32'hF);

    // Clear coinciding with a mismatch: clear wins
    clean("clr_relock", LOCK_N + 2);
    cycle("clr_hit", 1'b1, 1'b1, 16'h5555, 1'b1);
    chk("clr_cnt_s", 32'(err_count_s), 32'(0));
    chk("clr_cnt", 32'(err_count), 32'(0));
    clean("clr_after", 2);

    // Asynchronous reset between edges while locked
    bad("pre_rst", 1, 16'h0F0F);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    @(negedge clk);
    reset_n = 1'b1;
    gen     = 16'hACE1;
    clean("post_rst", LOCK_N);
    chk("post_rst_unlocked", 32'(locked), 32'(0));
    clean("post_rst_lock", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
